// File: rtl/prr_valid_sched.sv
// Loop-nest valid scheduler: walks an odometer of up to LOOP_LEVEL loops and pulses
// valid when the cycle counter reaches each iteration's target (sum of idx*stride).
module prr_valid_sched #(
    parameter int LOOP_LEVEL   = 4,
    parameter int EXTENT_WIDTH = 16,
    parameter int CNT_WIDTH    = 24
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic                                   stall,
    input  logic                                   flush,
    input  logic [$clog2(LOOP_LEVEL+1)-1:0]        cfg_dim,
    input  logic [LOOP_LEVEL-1:0][EXTENT_WIDTH-1:0] cfg_extent,
    input  logic [LOOP_LEVEL-1:0][CNT_WIDTH-1:0]    cfg_cycle_stride,
    output logic                                   valid,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   err_late
);

    // state | meaning
    // IDLE  | waiting for start, configuration not latched
    // RUN   | counting cycles, issuing valids, draining the output stage
    // DONE  | one cycle after the final valid/done, then back to IDLE

    localparam int DIM_W = $clog2(LOOP_LEVEL + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    logic [DIM_W-1:0]        dim_q;
    logic [EXTENT_WIDTH-1:0] ext_q    [LOOP_LEVEL];
    logic [CNT_WIDTH-1:0]    stride_q [LOOP_LEVEL];
    logic [EXTENT_WIDTH-1:0] idx      [LOOP_LEVEL];
    logic [EXTENT_WIDTH-1:0] idx_nxt  [LOOP_LEVEL];
    logic [CNT_WIDTH-1:0]    cycle_cnt;
    logic [CNT_WIDTH-1:0]    target;
    logic [CNT_WIDTH-1:0]    diff;
    logic                    hit;
    logic                    late;
    logic                    carry;
    logic                    last_iter;
    logic                    cfg_empty;
    logic                    issued;
    logic                    fire_q;
    logic                    last_q;
    logic                    late_q;
    logic                    late_vld;

    always_comb begin
        target    = '0;
        cfg_empty = (dim_q == '0);
        for (int i = 0; i < LOOP_LEVEL; i++) begin
            if (DIM_W'(i) < dim_q) begin
                target = target + (CNT_WIDTH'(idx[i]) * stride_q[i]);
                if (ext_q[i] == '0)
                    cfg_empty = 1'b1;
            end
        end
    end

    always_comb begin
        carry = 1'b1;
        for (int i = 0; i < LOOP_LEVEL; i++) begin
            idx_nxt[i] = idx[i];
            if ((DIM_W'(i) < dim_q) && carry) begin
                if (idx[i] == ext_q[i] - 1'b1) begin
                    idx_nxt[i] = '0;
                end else begin
                    idx_nxt[i] = idx[i] + 1'b1;
                    carry      = 1'b0;
                end
            end
        end
        last_iter = carry;
    end

    // Counter is ahead of the target by less than half the range: the target was missed.
    assign diff = cycle_cnt - target;
    assign hit  = (diff == '0);
    assign late = (diff != '0) && !diff[CNT_WIDTH-1];
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            dim_q     <= '0;
            cycle_cnt <= '0;
            for (int i = 0; i < LOOP_LEVEL; i++) begin
                idx[i]      <= '0;
                ext_q[i]    <= '0;
                stride_q[i] <= '0;
            end
            issued   <= 1'b0;
            fire_q   <= 1'b0;
            last_q   <= 1'b0;
            late_q   <= 1'b0;
            late_vld <= 1'b0;
            valid    <= 1'b0;
            done     <= 1'b0;
            err_late <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid    <= 1'b0;
                    done     <= 1'b0;
                    late_vld <= 1'b0;
                    fire_q   <= 1'b0;
                    last_q   <= 1'b0;
                    late_q   <= 1'b0;
                    if (start && !flush) begin
                        dim_q <= cfg_dim;
                        for (int i = 0; i < LOOP_LEVEL; i++) begin
                            ext_q[i]    <= cfg_extent[i];
                            stride_q[i] <= cfg_cycle_stride[i];
                            idx[i]      <= '0;
                        end
                        cycle_cnt <= '0;
                        issued    <= 1'b0;
                        err_late  <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        valid    <= 1'b0;
                        done     <= 1'b0;
                        late_vld <= 1'b0;
                        fire_q   <= 1'b0;
                        last_q   <= 1'b0;
                        late_q   <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        // err_late trails the late valid by one cycle
                        err_late <= err_late | late_vld;
                        if (done) begin
                            valid    <= 1'b0;
                            done     <= 1'b0;
                            late_vld <= 1'b0;
                            state    <= DONE;
                        end else if (stall) begin
                            valid    <= 1'b0;
                            late_vld <= 1'b0;
                        end else begin
                            valid     <= fire_q;
                            done      <= last_q;
                            late_vld  <= late_q;
                            fire_q    <= 1'b0;
                            last_q    <= 1'b0;
                            late_q    <= 1'b0;
                            cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
                            if (cfg_empty) begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end else if (!issued && (hit || late)) begin
                                fire_q <= 1'b1;
                                late_q <= late;
                                for (int i = 0; i < LOOP_LEVEL; i++)
                                    idx[i] <= idx_nxt[i];
                                if (last_iter) begin
                                    last_q <= 1'b1;
                                    issued <= 1'b1;
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    valid    <= 1'b0;
                    done     <= 1'b0;
                    late_vld <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prr_valid_sched.sv
// Bench for prr_valid_sched: directed schedules with fixed expected timelines plus
// randomized schedules checked against an iteration/target timeline model.
module tb_prr_valid_sched;

    localparam int LL   = 4;
    localparam int EW   = 16;
    localparam int CW   = 24;
    localparam int DW   = 3;
    localparam int MAXC = 256;

    logic                   clk = 1'b0;
    logic                   reset, start, stall, flush;
    logic [DW-1:0]          cfg_dim;
    logic [LL-1:0][EW-1:0]  cfg_extent;
    logic [LL-1:0][CW-1:0]  cfg_cycle_stride;
    logic                   valid, busy, done, err_late;

    int vectors = 0;
    int errors  = 0;

    int   c_dim;
    int   c_ext [LL];
    int   c_str [LL];
    bit   m_stall [MAXC];
    bit   m_start [MAXC];
    bit   m_flush [MAXC];
    logic [3:0] o_vec [MAXC];   // {valid, done, busy, err_late} after edge S+k
    logic [3:0] e_vec [MAXC];
    int   e_last;

    prr_valid_sched #(.LOOP_LEVEL(LL), .EXTENT_WIDTH(EW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .flush(flush),
        .cfg_dim(cfg_dim), .cfg_extent(cfg_extent), .cfg_cycle_stride(cfg_cycle_stride),
        .valid(valid), .busy(busy), .done(done), .err_late(err_late)
    );

    always #5 clk = ~clk;

    task automatic set_cfg(input int d, input int e0, input int e1, input int s0, input int s1);
        c_dim = d;
        c_ext[0] = e0; c_ext[1] = e1; c_ext[2] = 1; c_ext[3] = 1;
        c_str[0] = s0; c_str[1] = s1; c_str[2] = 0; c_str[3] = 0;
    endtask

    task automatic clear_stim();
        for (int k = 0; k < MAXC; k++) begin
            m_stall[k] = 1'b0; m_start[k] = 1'b0; m_flush[k] = 1'b0;
        end
    endtask

    // Start at edge S (k=0), then replay the stimulus tables while scrambling cfg.
    task automatic run_sched(input int ncyc);
        @(negedge clk);
        cfg_dim = DW'(c_dim);
        for (int i = 0; i < LL; i++) begin
            cfg_extent[i]       = EW'(c_ext[i]);
            cfg_cycle_stride[i] = CW'(c_str[i]);
        end
        start = 1'b1; stall = 1'b0; flush = 1'b0;
        @(posedge clk); #1;
        o_vec[0] = {valid, done, busy, err_late};
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            start = m_start[k]; stall = m_stall[k]; flush = m_flush[k];
            cfg_dim          = DW'($urandom_range(4, 0));
            cfg_extent       = {$urandom(), $urandom()};
            cfg_cycle_stride = {$urandom(), $urandom(), $urandom()};
            @(posedge clk); #1;
            o_vec[k] = {valid, done, busy, err_late};
        end
    endtask

    // Timeline model: iteration n is issued at the first counter value c >= previous+1 that
    // equals or has passed its target; its valid lands on the (c+2)-th unstalled edge.
    task automatic compute_expected();
        int nsl[$];
        bit empty, lt;
        int total, cur, c, wall, t, rem;
        longint acc, d;
        longint md;
        md = longint'(1) << CW;
        for (int k = 0; k < MAXC; k++) e_vec[k] = 4'b0000;
        for (int k = 1; k < MAXC; k++) if (!m_stall[k]) nsl.push_back(k);
        empty = (c_dim == 0);
        for (int i = 0; i < c_dim; i++) if (c_ext[i] == 0) empty = 1'b1;
        if (empty) begin
            e_last = nsl[0];
            e_vec[e_last][2] = 1'b1;
            for (int k = 0; k < e_last; k++) e_vec[k][1] = 1'b1;
            return;
        end
        total = 1;
        for (int i = 0; i < c_dim; i++) total = total * c_ext[i];
        cur = 0; wall = 0;
        for (int n = 0; n < total; n++) begin
            acc = 0; rem = n;
            for (int i = 0; i < c_dim; i++) begin
                acc = acc + longint'(rem % c_ext[i]) * longint'(c_str[i]);
                rem = rem / c_ext[i];
            end
            t = int'(acc % md);
            c = cur; lt = 1'b0;
            for (int g = 0; g < 100000; g++) begin
                d = (longint'(c) - longint'(t)) % md;
                if (d < 0) d = d + md;
                if (d == 0) break;
                if (d < md / 2) begin lt = 1'b1; break; end
                c++;
            end
            if (c + 1 >= nsl.size()) begin
                errors++;
                $display("FAIL model_window iteration %0d needs edge %0d beyond window", n, c + 1);
                e_last = MAXC - 4;
                return;
            end
            wall = nsl[c + 1];
            e_vec[wall][3] = 1'b1;
            if (lt) for (int k = wall + 1; k < MAXC; k++) e_vec[k][0] = 1'b1;
            cur = c + 1;
        end
        e_vec[wall][2] = 1'b1;
        for (int k = 0; k <= wall + 1; k++) e_vec[k][1] = 1'b1;
        e_last = wall + 1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; stall = 1'b1; flush = 1'b0;
        cfg_dim = 3'd2; cfg_extent = {$urandom(), $urandom()};
        cfg_cycle_stride = {$urandom(), $urandom(), $urandom()};
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({valid, done, busy, err_late} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state got %b want 0000", {valid, done, busy, err_late});
        end
        @(negedge clk); reset = 1'b0; start = 1'b0; stall = 1'b0;
    endtask

    task automatic test_basic();
        logic [3:0] ev;
        set_cfg(2, 3, 2, 2, 10); clear_stim(); run_sched(20);
        for (int k = 0; k <= 20; k++) begin
            ev = {(k == 2 || k == 4 || k == 6 || k == 12 || k == 14 || k == 16), k == 16, k <= 17, 1'b0};
            vectors++;
            if (o_vec[k] !== ev) begin
                errors++;
                $display("FAIL basic S+%0d got %b want %b", k, o_vec[k], ev);
            end
        end
    endtask

    task automatic test_stall();
        logic [3:0] ev;
        set_cfg(2, 3, 2, 2, 10); clear_stim();
        m_stall[3] = 1'b1; m_stall[4] = 1'b1; m_stall[5] = 1'b1;
        run_sched(23);
        for (int k = 0; k <= 23; k++) begin
            ev = {(k == 2 || k == 7 || k == 9 || k == 15 || k == 17 || k == 19), k == 19, k <= 20, 1'b0};
            vectors++;
            if (o_vec[k] !== ev) begin
                errors++;
                $display("FAIL stall S+%0d got %b want %b", k, o_vec[k], ev);
            end
        end
    endtask

    task automatic test_late();
        logic [3:0] ev;
        set_cfg(1, 3, 1, 0, 0); clear_stim(); run_sched(7);
        for (int k = 0; k <= 7; k++) begin
            ev = {(k >= 2 && k <= 4), k == 4, k <= 5, k >= 4};
            vectors++;
            if (o_vec[k] !== ev) begin
                errors++;
                $display("FAIL late S+%0d got %b want %b", k, o_vec[k], ev);
            end
        end
    endtask

    task automatic test_empty();
        logic [3:0] ev;
        for (int r = 0; r < 2; r++) begin
            if (r == 0) set_cfg(0, 3, 2, 2, 10);
            else        set_cfg(2, 2, 0, 1, 1);
            clear_stim(); run_sched(4);
            for (int k = 0; k <= 4; k++) begin
                ev = {1'b0, k == 1, k == 0, 1'b0};
                vectors++;
                if (o_vec[k] !== ev) begin
                    errors++;
                    $display("FAIL empty%0d S+%0d got %b want %b", r, k, o_vec[k], ev);
                end
            end
        end
    endtask

    task automatic test_flush();
        logic [3:0] ev;
        set_cfg(2, 3, 2, 2, 10); clear_stim();
        m_flush[5] = 1'b1; m_stall[5] = 1'b1;
        run_sched(7);
        for (int k = 0; k <= 7; k++) begin
            ev = {(k == 2 || k == 4), 1'b0, k <= 4, 1'b0};
            vectors++;
            if (o_vec[k] !== ev) begin
                errors++;
                $display("FAIL flush S+%0d got %b want %b", k, o_vec[k], ev);
            end
        end
        clear_stim(); run_sched(20);
        for (int k = 0; k <= 20; k++) begin
            ev = {(k == 2 || k == 4 || k == 6 || k == 12 || k == 14 || k == 16), k == 16, k <= 17, 1'b0};
            vectors++;
            if (o_vec[k] !== ev) begin
                errors++;
                $display("FAIL flush_replay S+%0d got %b want %b", k, o_vec[k], ev);
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [3:0] ev;
        set_cfg(2, 3, 2, 2, 10); clear_stim();
        m_start[5] = 1'b1; m_start[9] = 1'b1; m_start[17] = 1'b1; m_start[18] = 1'b1;
        run_sched(20);
        for (int k = 0; k <= 20; k++) begin
            ev = {(k == 2 || k == 4 || k == 6 || k == 12 || k == 14 || k == 16), k == 16, k <= 17, 1'b0};
            vectors++;
            if (o_vec[k] !== ev) begin
                errors++;
                $display("FAIL start_in_run S+%0d got %b want %b", k, o_vec[k], ev);
            end
        end
    endtask

    task automatic test_flush_start();
        @(negedge clk);
        cfg_dim = 3'd2; cfg_extent = {16'd1, 16'd1, 16'd2, 16'd3};
        cfg_cycle_stride = '0;
        start = 1'b1; flush = 1'b1; stall = 1'b0;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        for (int k = 0; k < 6; k++) begin
            vectors++;
            if ({valid, done, busy, err_late} !== 4'b0000) begin
                errors++;
                $display("FAIL flush_start +%0d got %b want 0000", k, {valid, done, busy, err_late});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midrun();
        set_cfg(1, 6, 1, 0, 0); clear_stim(); run_sched(5);
        vectors++;
        if (o_vec[5] !== 4'b1011) begin
            errors++;
            $display("FAIL midrun_before_reset got %b want 1011", o_vec[5]);
        end
        @(negedge clk); reset = 1'b1; flush = 1'b1; stall = 1'b1; start = 1'b1;
        @(negedge clk); reset = 1'b0; flush = 1'b0; stall = 1'b0; start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            vectors++;
            if ({valid, done, busy, err_late} !== 4'b0000) begin
                errors++;
                $display("FAIL midrun_reset +%0d got %b want 0000", k, {valid, done, busy, err_late});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int ncyc;
        for (int r = 0; r < 30; r++) begin
            c_dim = ($urandom_range(7, 0) == 0) ? 0 : $urandom_range(3, 1);
            for (int i = 0; i < LL; i++) begin
                c_ext[i] = ($urandom_range(11, 0) == 0) ? 0 : $urandom_range(3, 1);
                c_str[i] = $urandom_range(4, 0);
            end
            clear_stim();
            for (int k = 1; k < MAXC; k++) m_stall[k] = ($urandom_range(4, 0) == 0);
            compute_expected();
            for (int k = 1; k <= e_last; k++) m_start[k] = ($urandom_range(9, 0) == 0);
            ncyc = e_last + 3;
            run_sched(ncyc);
            for (int k = 0; k <= ncyc; k++) begin
                vectors++;
                if (o_vec[k] !== e_vec[k]) begin
                    errors++;
                    $display("FAIL random%0d dim=%0d S+%0d got %b want %b", r, c_dim, k, o_vec[k], e_vec[k]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0;
        cfg_dim = '0; cfg_extent = '0; cfg_cycle_stride = '0;
        test_reset();
        test_basic();
        test_stall();
        test_late();
        test_empty();
        test_flush();
        test_start_ignored();
        test_flush_start();
        test_reset_midrun();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
